// File: rtl/arith_pkg.sv
// Shared opcodes and FSM encoding for the sequential arithmetic unit.
package arith_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DIV  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per cycle, MSB first.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH:0]   pr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             run;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;
    logic             neg;

    assign shifted = {pr, q[WIDTH-1]};
    assign neg     = shifted < {2'b00, dvs};
    assign diff    = shifted[WIDTH:0] - {1'b0, dvs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr  <= '0;
            q   <= '0;
            dvs <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            pr  <= '0;
            q   <= a;
            dvs <= b;
            cnt <= CW'(WIDTH - 1);
            run <= 1'b1;
        end else if (run) begin
            // Restore by keeping the shifted value when the trial subtract underflows.
            if (neg) begin
                pr <= shifted[WIDTH:0];
                q  <= {q[WIDTH-2:0], 1'b0};
            end else begin
                pr <= diff;
                q  <= {q[WIDTH-2:0], 1'b1};
            end
            if (cnt == '0) begin
                run <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign busy      = run;
    assign done      = run && (cnt == '0);
    assign quotient  = q;
    assign remainder = pr[WIDTH-1:0];

endmodule

// File: rtl/seq_arith_unit.sv
// Registered add/sub/mul/div unit with valid/ready handshake on both sides.
module seq_arith_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic [WIDTH-1:0]   rem,
    output logic               div_by_zero,
    output logic               busy
);

    localparam int RW = 2 * WIDTH;

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic             load;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rmd;
    logic [RW-1:0]    res_n;
    logic [WIDTH-1:0] rem_n;
    logic             dbz_n;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = div_busy;

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .a         (a),
        .b         (b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rmd)
    );

    always_comb begin
        next_state = state;
        div_start  = 1'b0;
        load       = 1'b0;
        res_n      = '0;
        rem_n      = '0;
        dbz_n      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (sel)
                        OP_ADD: begin
                            load  = 1'b1;
                            res_n = RW'(a) + RW'(b);
                        end
                        OP_SUB: begin
                            load  = 1'b1;
                            res_n = RW'(a) - RW'(b);
                        end
                        OP_MUL: begin
                            load  = 1'b1;
                            res_n = RW'(a) * RW'(b);
                        end
                        OP_DIV: begin
                            if (b == '0) begin
                                load  = 1'b1;
                                res_n = '1;
                                rem_n = a;
                                dbz_n = 1'b1;
                            end else begin
                                div_start  = 1'b1;
                                next_state = DIV;
                            end
                        end
                    endcase
                end
            end
            DIV: begin
                if (div_done) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                load       = 1'b1;
                res_n      = RW'(quo);
                rem_n      = rmd;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            result      <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else if (load) begin
            out_valid   <= 1'b1;
            result      <= res_n;
            rem         <= rem_n;
            div_by_zero <= dbz_n;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
